lu_op_identifier: RTL and testbench
===================================

Name: lu_op_identifier

Overview:
- Receiving-end counterpart of the 2-input selectable logic unit (select 00=NOR, 01=OR, 10=XOR, 11=XNOR).
- Watches a stream of (a, b, s_out) samples taken from such a unit and narrows a candidate set until it can report which select code produced them.
- Reports an exact match, an ambiguous result (sample limit reached), or an inconsistency (no code fits).
- Used as a bench/self-check monitor beside the logic unit.

Parameters:
- MAX_SAMPLES, 8, samples accepted before giving up with ambiguous; legal range 1..255.
- CW, 8, width of the sample counter; must satisfy 2^CW > MAX_SAMPLES.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous reset, active-high.
- start  input  1  one-cycle pulse; begins or restarts an identification run.
- in_valid  input  1  sample present on a/b/s_in this cycle.
- a  input  1  logic unit operand a.
- b  input  1  logic unit operand b.
- s_in  input  1  observed logic unit output.
- ack  input  1  releases the result; returns DONE to IDLE.
- in_ready  output  1  high while samples are accepted (COLLECT only).
- done  output  1  result valid; held until ack or start.
- found  output  1  exactly one candidate remains; op is valid.
- ambiguous  output  1  MAX_SAMPLES samples consumed with two or more candidates left.
- error  output  1  no candidate fits the samples.
- op  output  2  identified select code; 00 unless found=1.
- cand  output  4  live candidate mask; bit k set means select code k is still consistent.
- count  output  CW  samples accepted in the current run.

Behaviour:
- Reset (asynchronous, any state): state=IDLE; all outputs 0, including cand=0000 and count=0.
- States: IDLE, COLLECT, DONE, encoded in a registered state machine.
- IDLE, start=1: next state COLLECT; cand<=1111; count<=0; flags cleared.
- COLLECT:
  - in_ready=1.
  - A sample is accepted when in_valid=1 and start=0.
  - Per accepted sample: cand_next[k] = cand[k] & (f_k(a,b) == s_in), where f_0=~(a|b), f_1=a|b, f_2=a^b, f_3=~(a^b).
  - count <= count+1.
- Exit from COLLECT, evaluated on cand_next/count_next in the accepting cycle:
  - Exactly one bit set: DONE, found=1, op=index of that bit.
  - cand_next=0000: DONE, error=1, op=00.
  - count_next==MAX_SAMPLES with two or more bits set: DONE, ambiguous=1, op=00.
  - Otherwise stay in COLLECT.
- Result flags, op and done register on the same edge that enters DONE, i.e. 1-cycle latency after the deciding sample.
- Exactly one of found/ambiguous/error is high while done=1.
- in_valid with no start in IDLE or DONE: ignored; nothing changes.
- DONE: done=1; cand, count and flags held stable. ack=1 → IDLE with done and flags cleared. cand and count hold their last values in IDLE.
- start in COLLECT or DONE: behaves as a fresh start (COLLECT, cand=1111, count=0, flags cleared). The sample presented in that cycle is discarded. start wins over simultaneous ack or in_valid.
- Discrimination facts the bench relies on:
  - Sample (0,0): 1 keeps {NOR, XNOR}; 0 keeps {OR, XOR}.
  - Sample (1,1): 1 keeps {OR, XNOR}; 0 keeps {NOR, XOR}.
  - Samples (0,1)/(1,0): 0 keeps {NOR, XNOR}; 1 keeps {OR, XOR}.
- Reset asserted mid-COLLECT or mid-DONE aborts immediately. No partial result survives.

Test Plan:
- Reset, start, samples (0,0,1) then (1,1,1) → cand 1111→1001→1000; next cycle done=1, found=1, op=11, count=2.
- Start, samples (0,1,1), (1,1,0) → cand 0110 then 0100; done, found=1, op=10 (XOR), count=2.
- Start, sample (0,0,1) then (1,0,1) → cand after second sample = 0000; done, error=1, op=00, count=2.
- MAX_SAMPLES=3; start, three samples (0,1,1) → cand stays 0110; after third, done, ambiguous=1, count=3.
- Mid-run checks:
  - Start, one sample, then start again with in_valid=1 → cand=1111, count=0, that sample ignored.
  - Assert rst mid-COLLECT → all outputs 0 asynchronously.
- In DONE, hold ack=0 for 5 cycles with in_valid toggling → outputs stable. ack=1 → IDLE, done=0. in_valid in IDLE → count unchanged.

Source files
------------

// File: rtl/lu_op_identifier_if.sv
// Bus bundle for lu_op_identifier: sample stream in, identification result out.
// master drives samples/control (bench or upstream), slave is the identifier.
interface lu_op_identifier_if #(
    parameter int CW = 8
);
    logic          start;
    logic          in_valid;
    logic          a;
    logic          b;
    logic          s_in;
    logic          ack;
    logic          in_ready;
    logic          done;
    logic          found;
    logic          ambiguous;
    logic          error;
    logic [1:0]    op;
    logic [3:0]    cand;
    logic [CW-1:0] count;
    logic [1:0]    state;

    modport master (
        output start, in_valid, a, b, s_in, ack,
        input  in_ready, done, found, ambiguous, error, op, cand, count, state
    );

    modport slave (
        input  start, in_valid, a, b, s_in, ack,
        output in_ready, done, found, ambiguous, error, op, cand, count, state
    );
endinterface

// File: rtl/lu_op_identifier.sv
// Identifies which select code (NOR/OR/XOR/XNOR) of a 2-input logic unit produced
// an observed stream of (a, b, s_in) samples by narrowing a 4-bit candidate mask.
module lu_op_identifier #(
    parameter int MAX_SAMPLES = 8,
    parameter int CW          = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    lu_op_identifier_if.slave       bus
);
    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_DONE    = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [3:0]    cand_q, cand_d;
    logic [CW-1:0] count_q, count_d;
    logic          found_q, found_d;
    logic          ambiguous_q, ambiguous_d;
    logic          error_q, error_d;
    logic [1:0]    op_q, op_d;

    logic [3:0]    match;
    logic [3:0]    cand_acc;
    logic [CW-1:0] count_acc;
    logic          accept;
    logic          single;
    logic [1:0]    single_idx;

    // Handshake: a sample transfers on a rising edge when in_valid && in_ready,
    // unless start is high in the same cycle (start discards that sample).
    assign accept    = (state_q == S_COLLECT) && bus.in_valid && !bus.start;
    assign cand_acc  = cand_q & match;
    assign count_acc = count_q + CW'(1);

    always_comb begin
        match[0] = (~(bus.a | bus.b)) == bus.s_in;
        match[1] = (bus.a | bus.b) == bus.s_in;
        match[2] = (bus.a ^ bus.b) == bus.s_in;
        match[3] = (~(bus.a ^ bus.b)) == bus.s_in;
    end

    always_comb begin
        single     = 1'b1;
        single_idx = 2'd0;
        case (cand_acc)
            4'b0001: single_idx = 2'd0;
            4'b0010: single_idx = 2'd1;
            4'b0100: single_idx = 2'd2;
            4'b1000: single_idx = 2'd3;
            default: single = 1'b0;
        endcase
    end

    // State register and result registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cand_q      <= 4'b0000;
            count_q     <= '0;
            found_q     <= 1'b0;
            ambiguous_q <= 1'b0;
            error_q     <= 1'b0;
            op_q        <= 2'b00;
        end else begin
            state_q     <= state_d;
            cand_q      <= cand_d;
            count_q     <= count_d;
            found_q     <= found_d;
            ambiguous_q <= ambiguous_d;
            error_q     <= error_d;
            op_q        <= op_d;
        end
    end

    // Next-state and next-result logic; start overrides everything else.
    always_comb begin
        state_d     = state_q;
        cand_d      = cand_q;
        count_d     = count_q;
        found_d     = found_q;
        ambiguous_d = ambiguous_q;
        error_d     = error_q;
        op_d        = op_q;
        if (bus.start) begin
            state_d     = S_COLLECT;
            cand_d      = 4'b1111;
            count_d     = '0;
            found_d     = 1'b0;
            ambiguous_d = 1'b0;
            error_d     = 1'b0;
            op_d        = 2'b00;
        end else begin
            case (state_q)
                S_COLLECT: begin
                    if (accept) begin
                        cand_d  = cand_acc;
                        count_d = count_acc;
                        if (single) begin
                            state_d = S_DONE;
                            found_d = 1'b1;
                            op_d    = single_idx;
                        end else if (cand_acc == 4'b0000) begin
                            state_d = S_DONE;
                            error_d = 1'b1;
                        end else if (count_acc == CW'(MAX_SAMPLES)) begin
                            state_d     = S_DONE;
                            ambiguous_d = 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    if (bus.ack) begin
                        state_d     = S_IDLE;
                        found_d     = 1'b0;
                        ambiguous_d = 1'b0;
                        error_d     = 1'b0;
                        op_d        = 2'b00;
                    end
                end
                default: ;
            endcase
        end
    end

    // Outputs are decoded purely from registers.
    always_comb begin
        bus.in_ready  = (state_q == S_COLLECT);
        bus.done      = (state_q == S_DONE);
        bus.found     = found_q;
        bus.ambiguous = ambiguous_q;
        bus.error     = error_q;
        bus.op        = op_q;
        bus.cand      = cand_q;
        bus.count     = count_q;
        bus.state     = state_q;
    end
endmodule

// File: tb/tb_lu_op_identifier.sv
// Directed bench for lu_op_identifier: expected results are queued per run and
// compared by a monitor on each rising edge of done.
module tb_lu_op_identifier;
  localparam int CW  = 8;
  localparam int MAX = 3;
  localparam int W   = 9 + CW;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  lu_op_identifier_if #(.CW(CW)) bus ();
  lu_op_identifier #(.MAX_SAMPLES(MAX), .CW(CW)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  logic [W-1:0] exp_q[$];
  logic [W-1:0] mon_exp;
  logic [W-1:0] result_obs;
  int checks   = 0;
  int failures = 0;
  logic done_q = 1'b0;

  function automatic logic [W-1:0] pack(input logic f, input logic am, input logic er,
                                        input logic [1:0] op, input logic [3:0] c,
                                        input logic [CW-1:0] n);
    return {f, am, er, op, c, n};
  endfunction

  assign result_obs = {bus.found, bus.ambiguous, bus.error, bus.op, bus.cand, bus.count};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Monitor: one expected result per DONE entry.
  always @(negedge clk) begin
    if (rst) begin
      done_q = 1'b0;
    end else begin
      if (bus.done && !done_q) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL result_unexpected actual=%h expected=none", result_obs);
        end else begin
          mon_exp = exp_q.pop_front();
          if (result_obs !== mon_exp) begin
            failures++;
            $display("FAIL result actual=%h expected=%h", result_obs, mon_exp);
          end
        end
      end
      done_q = bus.done;
    end
  end

  // Driver tasks: inputs change 1 time unit after the rising edge.
  task automatic do_start();
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  task automatic do_ack();
    bus.ack = 1'b1;
    @(posedge clk); #1;
    bus.ack = 1'b0;
  endtask

  task automatic send(input logic sa, input logic sb, input logic ss);
    bus.in_valid = 1'b1;
    bus.a = sa;
    bus.b = sb;
    bus.s_in = ss;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
    check(name, exp_q.size(), 0);
    @(posedge clk); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.start = 1'b0; bus.in_valid = 1'b0; bus.a = 1'b0; bus.b = 1'b0;
    bus.s_in = 1'b0; bus.ack = 1'b0;
    #12;
    check("reset_result", result_obs, '0);
    check("reset_done_ready", {bus.done, bus.in_ready, bus.state}, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // XNOR identified after (0,0,1),(1,1,1)
    do_start();
    check("start_cand_count", {bus.cand, bus.count}, {4'b1111, 8'd0});
    check("start_in_ready", bus.in_ready, 1);
    exp_q.push_back(pack(1'b1, 1'b0, 1'b0, 2'd3, 4'b1000, 8'd2));
    send(1'b0, 1'b0, 1'b1);
    check("xnor_cand1", bus.cand, 4'b1001);
    send(1'b1, 1'b1, 1'b1);
    check("xnor_done", bus.done, 1);
    drain("drain_xnor");
    do_ack();
    check("xnor_ack_done", {bus.done, bus.found, bus.state}, 0);

    // XOR identified after (0,1,1),(1,1,0)
    do_start();
    exp_q.push_back(pack(1'b1, 1'b0, 1'b0, 2'd2, 4'b0100, 8'd2));
    send(1'b0, 1'b1, 1'b1);
    check("xor_cand1", bus.cand, 4'b0110);
    send(1'b1, 1'b1, 1'b0);
    drain("drain_xor");
    do_ack();

    // Inconsistent stream -> error
    do_start();
    exp_q.push_back(pack(1'b0, 1'b0, 1'b1, 2'd0, 4'b0000, 8'd2));
    send(1'b0, 1'b0, 1'b1);
    send(1'b1, 1'b0, 1'b1);
    check("err_cand", bus.cand, 4'b0000);
    drain("drain_err");
    do_ack();

    // Sample limit reached with {OR,XOR} left -> ambiguous
    do_start();
    exp_q.push_back(pack(1'b0, 1'b1, 1'b0, 2'd0, 4'b0110, 8'd3));
    for (int i = 0; i < 3; i++) begin
      send(1'b0, 1'b1, 1'b1);
      check("amb_cand", bus.cand, 4'b0110);
    end
    drain("drain_amb");
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = i[0];
      bus.a = 1'($urandom_range(0, 1));
      bus.b = 1'($urandom_range(0, 1));
      bus.s_in = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      check("done_hold", {bus.done, result_obs},
            {1'b1, pack(1'b0, 1'b1, 1'b0, 2'd0, 4'b0110, 8'd3)});
    end
    bus.in_valid = 1'b0;
    do_ack();
    check("amb_ack_done", {bus.done, bus.ambiguous, bus.state}, 0);
    send(1'b1, 1'b0, 1'b1);
    check("idle_ignore", {bus.state, bus.cand, bus.count}, {2'd0, 4'b0110, 8'd3});

    // Restart mid-run discards the concurrent sample, then NOR is found
    do_start();
    send(1'b0, 1'b0, 1'b1);
    check("restart_pre_count", bus.count, 1);
    bus.start = 1'b1; bus.in_valid = 1'b1; bus.a = 1'b1; bus.b = 1'b1; bus.s_in = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.in_valid = 1'b0;
    check("restart_state", {bus.state, bus.cand, bus.count}, {2'd1, 4'b1111, 8'd0});
    exp_q.push_back(pack(1'b1, 1'b0, 1'b0, 2'd0, 4'b0001, 8'd2));
    send(1'b1, 1'b1, 1'b0);
    check("nor_cand1", bus.cand, 4'b0101);
    send(1'b0, 1'b1, 1'b0);
    drain("drain_nor");
    do_ack();

    // Asynchronous reset mid-COLLECT
    do_start();
    send(1'b1, 1'b1, 1'b1);
    check("pre_rst_cand", bus.cand, 4'b1010);
    rst = 1'b1;
    #2;
    check("async_rst_result", result_obs, '0);
    check("async_rst_flags", {bus.done, bus.in_ready, bus.state}, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check("post_rst_idle", {bus.state, bus.done}, 0);

    check("queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
